// File: rtl/ic74hc151_scan_ctrl.sv
// Scans the enabled channels of a 74HC151 8:1 mux and collects the Y bits into one word.
// Latency: N enabled channels * (SETTLE_CYCLES+1) edges from Start to DONE; Valid is high in the DONE cycle.
// Backpressure: none. Start is taken only in IDLE and ignored otherwise. Define YF_CHECK_EN to enable the Y/YF consistency check.
module ic74hc151_scan_ctrl #(
    parameter int DATA_SelectPart  = 3,
    parameter int DATA_Single_Part = 8,   // must equal 2**DATA_SelectPart
    parameter int SETTLE_CYCLES    = 2    // 1..255
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Start,
    input  logic [DATA_Single_Part-1:0] ChanMask,
    input  logic                        Y,
    input  logic                        YF,
    output logic                        EN_Part,
    output logic [DATA_SelectPart-1:0]  SelectPart,
    output logic [DATA_Single_Part-1:0] Data_Part,
    output logic                        Valid,
    output logic                        Busy,
    output logic                        Error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0]                  state_q,  state_d;
    logic [7:0]                  cnt_q,    cnt_d;
    logic [DATA_Single_Part-1:0] mask_q,   mask_d;
    logic [DATA_SelectPart-1:0]  sel_q,    sel_d;
    logic [DATA_Single_Part-1:0] shadow_q, shadow_d;
    logic [DATA_Single_Part-1:0] data_q,   data_d;
    logic                        valid_q,  valid_d;
    logic                        busy_q,   busy_d;
    logic                        en_q,     en_d;

    logic [DATA_SelectPart-1:0]  first_sel;
    logic                        first_any;
    logic [DATA_SelectPart-1:0]  next_sel;
    logic                        next_any;

    // Find the lowest enabled channel in the incoming mask.
    always_comb begin
        first_sel = '0;
        first_any = 1'b0;
        for (int i = DATA_Single_Part - 1; i >= 0; i--) begin
            if (ChanMask[i]) begin
                first_sel = DATA_SelectPart'(i);
                first_any = 1'b1;
            end
        end
    end

    // Find the next enabled channel above the current one in the latched mask.
    always_comb begin
        next_sel = sel_q;
        next_any = 1'b0;
        for (int i = DATA_Single_Part - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_sel = DATA_SelectPart'(i);
                next_any = 1'b1;
            end
        end
    end

`ifdef YF_CHECK_EN
    logic err_q, err_d;

    // Sticky error: cleared by an accepted Start, set when Y and YF agree at a sample.
    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && Start) begin
            err_d = 1'b0;
        end else if (state_q == S_SAMPLE && (Y == YF)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Error = err_q;
`else
    // Complement output is not checked in this build.
    logic unused_yf;
    assign unused_yf = YF;
    assign Error     = 1'b0;
`endif

    // Scan sequencer: next-state and output-register values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        en_d     = en_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mask_d   = ChanMask;
                    shadow_d = '0;
                    cnt_d    = '0;
                    if (first_any) begin
                        sel_d   = first_sel;
                        en_d    = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_SETTLE;
                    end else begin
                        // Nothing to scan: report an all-zero word straight away.
                        data_d  = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                shadow_d[sel_q] = Y;
                if (next_any) begin
                    sel_d   = next_sel;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    data_d  = shadow_d;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    en_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to idle with the mux disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            en_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
        end
    end

    assign EN_Part    = en_q;
    assign SelectPart = sel_q;
    assign Data_Part  = data_q;
    assign Valid      = valid_q;
    assign Busy       = busy_q;

endmodule
